// File: rtl/lsu_arbiter_if.sv
// Requester-side handshake bundle for lsu_arbiter: two requesters share one
// load/store path; index 0 is the core, index 1 is the program loader.
interface lsu_arbiter_if #(
    parameter int W = 8
) ();
    logic [1:0]        req;
    logic [1:0]        is_store;
    logic [1:0][W-1:0] base;
    logic [1:0][W-1:0] offset;
    logic [1:0][W-1:0] wdata;
    logic [1:0]        done;
    logic [W-1:0]      rdata;
    logic              busy;

    modport master (
        output req, is_store, base, offset, wdata,
        input  done, rdata, busy
    );

    modport slave (
        input  req, is_store, base, offset, wdata,
        output done, rdata, busy
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Round-robin load/store controller sharing one ALU address path and one
// data-memory port between two requesters.
//
// state  | meaning
// IDLE   | waiting for a request; winner and its operands latched on grant
// ADDR   | ALU computes address from latched base/offset; result registered
// ACCESS | memory written (store) or read into rdata (load) on exiting edge
// RESP   | one-cycle done pulse to the granted requester
module lsu_arbiter #(
    parameter int         W      = 8,
    parameter logic [2:0] OP_LD  = 3'b110,
    parameter logic [2:0] OP_ST  = 3'b111,
    parameter logic [2:0] OP_NOP = 3'b000
) (
    input  logic         clk,
    input  logic         reset,
    lsu_arbiter_if.slave rq,
    output logic [2:0]   alu_cmd,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [W-1:0] alu_c,
    input  logic [W-1:0] alu_rslt,
    output logic [W-1:0] dm_addr,
    output logic [W-1:0] dm_dat_in,
    output logic         dm_wr_en,
    input  logic [W-1:0] dm_dat_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         grant_q;
    logic         last_grant_q;
    logic         store_q;
    logic [W-1:0] base_q;
    logic [W-1:0] offset_q;
    logic [W-1:0] wdata_q;
    logic [W-1:0] addr_q;
    logic [W-1:0] rdata_q;
    logic [1:0]   done_d;

    logic gnt_valid;
    logic gnt_idx;

    // On a tie the requester that did not win last time goes first.
    assign gnt_valid = |rq.req;
    assign gnt_idx   = (rq.req == 2'b11) ? ~last_grant_q : rq.req[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            store_q      <= 1'b0;
            base_q       <= '0;
            offset_q     <= '0;
            wdata_q      <= '0;
            addr_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gnt_valid) begin
                grant_q      <= gnt_idx;
                last_grant_q <= gnt_idx;
                store_q      <= rq.is_store[gnt_idx];
                base_q       <= rq.base[gnt_idx];
                offset_q     <= rq.offset[gnt_idx];
                wdata_q      <= rq.wdata[gnt_idx];
            end
            if (state_q == ADDR) begin
                addr_q <= alu_rslt;
            end
            if (state_q == ACCESS && !store_q) begin
                rdata_q <= dm_dat_out;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 2'b00;
        alu_cmd   = OP_NOP;
        alu_a     = '0;
        alu_b     = '0;
        alu_c     = '0;
        dm_addr   = '0;
        dm_dat_in = '0;
        dm_wr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                alu_cmd = store_q ? OP_ST : OP_LD;
                alu_a   = base_q;
                alu_b   = wdata_q;
                alu_c   = offset_q;
                state_d = ACCESS;
            end
            ACCESS: begin
                dm_addr = addr_q;
                if (store_q) begin
                    dm_dat_in = wdata_q;
                    dm_wr_en  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                done_d[grant_q] = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rq.done  = done_d;
    assign rq.rdata = rdata_q;
    assign rq.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with behavioural ALU (a + c) and data memory.
module tb_lsu_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [2:0]   alu_cmd;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_c;
    logic [W-1:0] alu_rslt;
    logic [W-1:0] dm_addr;
    logic [W-1:0] dm_dat_in;
    logic         dm_wr_en;
    logic [W-1:0] dm_dat_out;

    logic [W-1:0] mem [256] = '{default: 8'h00};

    int n_cmp = 0;
    int n_bad = 0;

    lsu_arbiter_if #(.W(W)) rq_if ();

    lsu_arbiter #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rq         (rq_if.slave),
        .alu_cmd    (alu_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_rslt   (alu_rslt),
        .dm_addr    (dm_addr),
        .dm_dat_in  (dm_dat_in),
        .dm_wr_en   (dm_wr_en),
        .dm_dat_out (dm_dat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign alu_rslt   = alu_a + alu_c;
    assign dm_dat_out = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_wr_en) mem[dm_addr] <= dm_dat_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from an idle DUT and waits (bounded) for its done.
    task automatic run_access(input int idx, input logic st, input logic [W-1:0] b,
                              input logic [W-1:0] o, input logic [W-1:0] d,
                              output int lat, output logic [W-1:0] rd,
                              output logic [2:0] cmd, output logic [1:0] dn);
        rq_if.is_store[idx] = st;
        rq_if.base[idx]     = b;
        rq_if.offset[idx]   = o;
        rq_if.wdata[idx]    = d;
        rq_if.req[idx]      = 1'b1;
        lat = -1;
        rd  = '0;
        cmd = 3'b000;
        dn  = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) cmd = alu_cmd;
            if (rq_if.done != 2'b00) begin
                lat = c;
                rd  = rq_if.rdata;
                dn  = rq_if.done;
                break;
            end
        end
        rq_if.req[idx] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rq_if.req = 2'b00;
        tick();
        tick();
        n_cmp++;
        if (rq_if.busy !== 1'b0 || rq_if.done !== 2'b00 || dm_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b wr_en=%b, required 0/00/0",
                     rq_if.busy, rq_if.done, dm_wr_en);
        end
        n_cmp++;
        if (rq_if.rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h, required 00", rq_if.rdata);
        end
        n_cmp++;
        if (alu_cmd !== 3'b000 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_c !== 8'h00
            || dm_addr !== 8'h00 || dm_dat_in !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_bus: cmd=%b a=%h b=%h c=%h addr=%h din=%h, required all 0",
                     alu_cmd, alu_a, alu_b, alu_c, dm_addr, dm_dat_in);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_store();
        rq_if.is_store[0] = 1'b1;
        rq_if.base[0]     = 8'd10;
        rq_if.offset[0]   = 8'd0;
        rq_if.wdata[0]    = 8'd32;
        rq_if.req         = 2'b01;
        tick();
        n_cmp++;
        if (alu_cmd !== 3'b111 || alu_a !== 8'd10 || alu_b !== 8'd32 || alu_c !== 8'd0
            || rq_if.busy !== 1'b1 || dm_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL store_addr: cmd=%b a=%0d b=%0d c=%0d busy=%b wr=%b, required 111/10/32/0/1/0",
                     alu_cmd, alu_a, alu_b, alu_c, rq_if.busy, dm_wr_en);
        end
        tick();
        n_cmp++;
        if (dm_wr_en !== 1'b1 || dm_addr !== 8'd10 || dm_dat_in !== 8'd32
            || alu_cmd !== 3'b000 || rq_if.done !== 2'b00) begin
            n_bad++;
            $display("FAIL store_access: wr=%b addr=%0d din=%0d cmd=%b done=%b, required 1/10/32/000/00",
                     dm_wr_en, dm_addr, dm_dat_in, alu_cmd, rq_if.done);
        end
        tick();
        n_cmp++;
        if (rq_if.done !== 2'b01 || dm_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL store_done: done=%b wr=%b, required 01/0", rq_if.done, dm_wr_en);
        end
        rq_if.req = 2'b00;
        tick();
        n_cmp++;
        if (rq_if.done !== 2'b00 || rq_if.busy !== 1'b0 || mem[10] !== 8'd32) begin
            n_bad++;
            $display("FAIL store_after: done=%b busy=%b mem10=%0d, required 00/0/32",
                     rq_if.done, rq_if.busy, mem[10]);
        end
    endtask

    task automatic test_store_load();
        int lat;
        logic [W-1:0] rd;
        logic [2:0] cmd;
        logic [1:0] dn;
        run_access(0, 1'b1, 8'd4, 8'd0, 8'd46, lat, rd, cmd, dn);
        n_cmp++;
        if (lat != 3 || dn !== 2'b01 || cmd !== 3'b111 || mem[4] !== 8'd46) begin
            n_bad++;
            $display("FAIL st46: lat=%0d done=%b cmd=%b mem4=%0d, required 3/01/111/46",
                     lat, dn, cmd, mem[4]);
        end
        run_access(0, 1'b0, 8'd4, 8'd0, 8'd0, lat, rd, cmd, dn);
        n_cmp++;
        if (lat != 3 || dn !== 2'b01 || cmd !== 3'b110 || rd !== 8'd46) begin
            n_bad++;
            $display("FAIL ld0: lat=%0d done=%b cmd=%b rdata=%0d, required 3/01/110/46",
                     lat, dn, cmd, rd);
        end
        run_access(1, 1'b0, 8'd2, 8'd2, 8'd0, lat, rd, cmd, dn);
        n_cmp++;
        if (lat != 3 || dn !== 2'b10 || cmd !== 3'b110 || rd !== 8'd46) begin
            n_bad++;
            $display("FAIL ld1_offset: lat=%0d done=%b cmd=%b rdata=%0d, required 3/10/110/46",
                     lat, dn, cmd, rd);
        end
        n_cmp++;
        if (rq_if.rdata !== 8'd46) begin
            n_bad++;
            $display("FAIL rdata_hold: got %0d, required 46", rq_if.rdata);
        end
    endtask

    task automatic test_latch();
        rq_if.is_store[0] = 1'b1;
        rq_if.base[0]     = 8'd10;
        rq_if.offset[0]   = 8'd0;
        rq_if.wdata[0]    = 8'h55;
        rq_if.req         = 2'b01;
        tick();
        rq_if.base[0]  = 8'd99;
        rq_if.wdata[0] = 8'h66;
        #1;
        n_cmp++;
        if (alu_a !== 8'd10 || alu_b !== 8'h55) begin
            n_bad++;
            $display("FAIL latch_alu: a=%0d b=%h, required 10/55", alu_a, alu_b);
        end
        tick();
        n_cmp++;
        if (dm_addr !== 8'd10 || dm_wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL latch_addr: addr=%0d wr=%b, required 10/1", dm_addr, dm_wr_en);
        end
        tick();
        n_cmp++;
        if (rq_if.done !== 2'b01 || rq_if.rdata !== 8'd46) begin
            n_bad++;
            $display("FAIL latch_done: done=%b rdata=%0d, required 01/46", rq_if.done, rq_if.rdata);
        end
        rq_if.req = 2'b00;
        tick();
        n_cmp++;
        if (mem[10] !== 8'h55 || mem[99] !== 8'h00) begin
            n_bad++;
            $display("FAIL latch_mem: mem10=%h mem99=%h, required 55/00", mem[10], mem[99]);
        end
    endtask

    task automatic test_contention();
        logic [1:0] seq [4];
        logic [1:0] exp_seq [4];
        int k = 0;
        int wr_cnt = 0;
        int viol = 0;
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10;
        for (int i = 0; i < 4; i++) seq[i] = 2'b00;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rq_if.is_store  = 2'b11;
        rq_if.base[0]   = 8'd20;
        rq_if.base[1]   = 8'd30;
        rq_if.offset[0] = 8'd0;
        rq_if.offset[1] = 8'd0;
        rq_if.wdata[0]  = 8'hA0;
        rq_if.wdata[1]  = 8'hB1;
        rq_if.req       = 2'b11;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (rq_if.done != 2'b00) begin
                if (k < 4) seq[k] = rq_if.done;
                k++;
            end
            if (dm_wr_en) begin
                wr_cnt++;
                if (!rq_if.busy || rq_if.done != 2'b00 || alu_cmd != 3'b000) viol++;
            end
        end
        rq_if.req = 2'b00;
        tick();
        n_cmp++;
        if (k != 4) begin
            n_bad++;
            $display("FAIL cont_count: done pulses=%0d, required 4", k);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (seq[i] !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL cont_order[%0d]: done=%b, required %b", i, seq[i], exp_seq[i]);
            end
        end
        n_cmp++;
        if (wr_cnt != 4 || viol != 0) begin
            n_bad++;
            $display("FAIL cont_wr: writes=%0d stray=%0d, required 4/0", wr_cnt, viol);
        end
        n_cmp++;
        if (mem[20] !== 8'hA0 || mem[30] !== 8'hB1) begin
            n_bad++;
            $display("FAIL cont_mem: mem20=%h mem30=%h, required A0/B1", mem[20], mem[30]);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        rq_if.is_store[0] = 1'b1;
        rq_if.base[0]     = 8'd5;
        rq_if.offset[0]   = 8'd0;
        rq_if.wdata[0]    = 8'd77;
        rq_if.req         = 2'b01;
        tick();
        n_cmp++;
        if (rq_if.busy !== 1'b1 || alu_cmd !== 3'b111) begin
            n_bad++;
            $display("FAIL mid_addr: busy=%b cmd=%b, required 1/111", rq_if.busy, alu_cmd);
        end
        reset     = 1'b0;
        rq_if.req = 2'b00;
        tick();
        if (rq_if.done != 2'b00) done_seen++;
        n_cmp++;
        if (rq_if.busy !== 1'b0 || dm_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_idle: busy=%b wr=%b, required 0/0", rq_if.busy, dm_wr_en);
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rq_if.done != 2'b00) done_seen++;
        end
        n_cmp++;
        if (mem[5] !== 8'h00 || done_seen != 0) begin
            n_bad++;
            $display("FAIL mid_drop: mem5=%0d dones=%0d, required 0/0", mem[5], done_seen);
        end
        rq_if.is_store  = 2'b00;
        rq_if.base[0]   = 8'd10;
        rq_if.base[1]   = 8'd4;
        rq_if.offset[0] = 8'd0;
        rq_if.offset[1] = 8'd0;
        rq_if.req       = 2'b11;
        tick();
        tick();
        tick();
        n_cmp++;
        if (rq_if.done !== 2'b01 || rq_if.rdata !== 8'h55) begin
            n_bad++;
            $display("FAIL mid_first_grant: done=%b rdata=%h, required 01/55", rq_if.done, rq_if.rdata);
        end
        rq_if.req = 2'b10;
        tick();
        tick();
        tick();
        tick();
        n_cmp++;
        if (rq_if.done !== 2'b10 || rq_if.rdata !== 8'd46) begin
            n_bad++;
            $display("FAIL mid_second_grant: done=%b rdata=%0d, required 10/46", rq_if.done, rq_if.rdata);
        end
        rq_if.req = 2'b00;
        tick();
    endtask

    task automatic test_idle();
        rq_if.req = 2'b00;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (rq_if.busy !== 1'b0 || rq_if.done !== 2'b00 || dm_wr_en !== 1'b0 || alu_cmd !== 3'b000) begin
                n_bad++;
                $display("FAIL idle[%0d]: busy=%b done=%b wr=%b cmd=%b, required 0/00/0/000",
                         c, rq_if.busy, rq_if.done, dm_wr_en, alu_cmd);
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        rq_if.req      = 2'b00;
        rq_if.is_store = 2'b00;
        rq_if.base     = '0;
        rq_if.offset   = '0;
        rq_if.wdata    = '0;
        test_reset();
        test_single_store();
        test_store_load();
        test_latch();
        test_contention();
        test_reset_mid();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Load/store controller that shares one alu address path and one dat_mem port between two requesters: the core (requester 0) and the test/program loader (requester 1).
- Arbitrates between the two requesters round-robin.
- Sequences each access: the ALU computes the address, then memory is written or read, then a one-cycle done response is returned.
- Sits in top_level between the requesters and the alu/dat_mem instances. It replaces testbench-driven OP/inA/inB/inC/DM_write sequencing.

Parameters:
- W, 8, data/address width
- OP_LD, 3'b110, alu_cmd driven for a load address computation
- OP_ST, 3'b111, alu_cmd driven for a store address computation
- OP_NOP, 3'b000, alu_cmd driven when idle

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-low (0 = reset, sampled on posedge clk)
- req  in  2  per-requester request; level, held until matching done
- is_store  in  2  per-requester: 1 = store, 0 = load
- base  in  2xW  per-requester base operand, driven to ALU inA
- offset  in  2xW  per-requester offset operand, driven to ALU inC
- wdata  in  2xW  per-requester store data, driven to ALU inB and dm_dat_in
- done  out  2  one-cycle completion pulse per requester
- rdata  out  W  load data, valid in the cycle done is high; holds its value otherwise
- busy  out  1  high whenever state != IDLE
- alu_cmd  out  3  to alu
- alu_a, alu_b, alu_c  out  W each  to alu inA/inB/inC
- alu_rslt  in  W  from alu; used as memory address
- dm_addr  out  W  to dat_mem addr
- dm_dat_in  out  W  to dat_mem dat_in
- dm_wr_en  out  1  to dat_mem wr_en
- dm_dat_out  in  W  from dat_mem; combinational read of dm_addr

Behaviour:
- Reset (reset==0 at a posedge) produces:
  - state=IDLE, done=0, rdata=0, busy=0, dm_wr_en=0.
  - alu_cmd=OP_NOP, alu_a/b/c=0, dm_addr=0, dm_dat_in=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation: returns to IDLE at that edge.
  - An in-flight store whose ACCESS edge has not yet occurred is dropped (no write).
  - No done is issued for the aborted request.
- States: IDLE -> ADDR -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, grant one and go to ADDR.
  - Only one requester asserted: it wins.
  - Both asserted: the requester != last_grant wins, and last_grant is updated.
  - The winner's index, is_store, base, offset and wdata are registered. Later changes on the input ports are ignored until done.
- ADDR:
  - alu_cmd = OP_ST for a store, OP_LD for a load.
  - alu_a=base, alu_b=wdata, alu_c=offset.
  - alu_rslt is registered into the address register at the end of the cycle.
- ACCESS:
  - dm_addr = registered address.
  - Store: dm_dat_in=wdata and dm_wr_en=1 for exactly this cycle; memory is written on the exiting edge.
  - Load: dm_wr_en=0 and dm_dat_out is captured into rdata on the exiting edge.
- RESP:
  - done[grant]=1 for exactly one cycle. The other done bit stays 0.
  - rdata holds the loaded value; it is unchanged by a store.
- Outside ADDR, ALU outputs are OP_NOP/0. dm_wr_en is high only in ACCESS of a store.
- Latency: request accepted at edge N, done high during cycle N+3. Back-to-back throughput is one access per 4 cycles.
- Back-to-back requests:
  - A requester whose req is still high in the cycle after RESP is a new request.
  - The requester must drop req in its done cycle to avoid a repeat.
  - Round-robin guarantees alternation when both are continuously requesting.
- A req that deasserts before its grant is simply not served. A req that deasserts after its grant does not cancel the access.
- Arithmetic: the address is exactly alu_rslt, truncated to W bits; wrap-around is the ALU's concern. No address range check is performed.

Test Plan:
- Single store: req=01, is_store[0]=1, base[0]=10, offset[0]=0, wdata[0]=32:
  - alu_cmd=111 during ADDR.
  - dm_wr_en=1 for one cycle at addr 10.
  - done=01 three cycles after acceptance.
  - dat_mem[10]=32.
- Store then load: store 46 at addr 4, then load base=4 from requester 0 -> rdata=46 with done[0]=1; alu_cmd=110 in the load's ADDR cycle.
- Contention: req=11 held continuously with distinct stores -> grants alternate 0,1,0,1. Each done is one cycle; dm_wr_en is never high outside ACCESS.
- Operand latching: change base[0] from 10 to 99 during ADDR -> the write still lands at addr 10.
- Reset mid-operation: reset=0 at the ADDR cycle of a store of 77 to addr 5 ->
  - dat_mem[5] unchanged.
  - No done issued.
  - busy=0 the next cycle.
  - The first grant after reset goes to requester 0.
- Idle: req=00 for 20 cycles -> busy=0, done=00, dm_wr_en=0, alu_cmd=000 throughout.
